// File: rtl/skf_check_pkg.sv
// skf_check_pkg: shared definitions for the exhaustive Skolem-function checkers.
// Holds the checker FSM state encoding and the xor-family correctness predicate,
// so that other xor_N_M checkers can evaluate the same relation.
package skf_check_pkg;

    // Widest input/output vectors any checker hands to spec_holds().
    localparam int SKF_MAX_IN  = 16;
    localparam int SKF_MAX_OUT = 8;

    // Checker sweep state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } skf_state_e;

    // Even parity over every input and output bit together. Callers zero-extend
    // narrower vectors; zero padding does not change the parity.
    function automatic logic spec_holds(input logic [SKF_MAX_IN-1:0]  in_v,
                                        input logic [SKF_MAX_OUT-1:0] out_v);
        return ~((^in_v) ^ (^out_v));
    endfunction

endpackage

// File: rtl/skf_vec_counter.sv
// skf_vec_counter: W-bit input-vector enumerator for the exhaustive sweep.
// clr_i has priority over en_i; last_o flags the all-ones terminal vector so the
// controller can stop before the counter would wrap.
module skf_vec_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] vec_o,
    output logic         last_o
);

    logic [W-1:0] vec_q;
    logic [W-1:0] vec_d;

    // Next count: clear to zero, advance by one, or hold.
    always_comb begin
        vec_d = vec_q;
        if (clr_i) begin
            vec_d = '0;
        end else if (en_i) begin
            vec_d = vec_q + W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    assign vec_o  = vec_q;
    assign last_o = &vec_q;

endmodule

// File: rtl/skolem_exhaustive_checker.sv
// skolem_exhaustive_checker: drives every NUM_IN-bit assignment into a purely
// combinational Skolem block, checks even parity over {inputs, outputs} for each
// one, and reports pass/fail, the failure count and the first counterexample.
//
// Build option: define SKF_STOP_ON_FAIL_EN to end the sweep at the first failing
// vector (fail_count = 1). Without it the full sweep always completes.
//
// Handshake: there is none toward the Skolem block; skf_out must settle within
// one clock period of skf_in changing. start is a single-cycle request honoured
// only in IDLE or DONE; while busy it is ignored.
module skolem_exhaustive_checker
    import skf_check_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int NUM_OUT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [NUM_IN-1:0]   skf_in,
    input  logic [NUM_OUT-1:0]  skf_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [NUM_IN:0]     fail_count,
    output logic                cex_valid,
    output logic [NUM_IN-1:0]   cex_in,
    output logic [NUM_OUT-1:0]  cex_out,
    output logic [1:0]          dbg_state
);

    skf_state_e         state_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [NUM_IN:0]    fail_count_q;
    logic               cex_valid_q;
    logic [NUM_IN-1:0]  cex_in_q;
    logic [NUM_OUT-1:0] cex_out_q;

    logic [NUM_IN-1:0]  vec;
    logic               vec_last;
    logic               start_ok;
    logic               vec_fail;
    logic               cnt_en;
    logic [NUM_IN:0]    fail_count_inc;

    // A sweep may only be launched from IDLE or DONE.
    assign start_ok = start && (state_q != RUN);

    // The vector currently on skf_in is judged against the settled Skolem outputs.
    assign vec_fail = ~spec_holds(SKF_MAX_IN'(vec), SKF_MAX_OUT'(skf_out));

    assign fail_count_inc = fail_count_q + (NUM_IN + 1)'(1);

    // Advance only inside a sweep and never past the terminal vector, so skf_in
    // holds the last evaluated vector once the sweep ends.
`ifdef SKF_STOP_ON_FAIL_EN
    assign cnt_en = (state_q == RUN) && !vec_last && !vec_fail;
`else
    assign cnt_en = (state_q == RUN) && !vec_last;
`endif

    skf_vec_counter #(
        .W (NUM_IN)
    ) u_vec_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_ok),
        .en_i   (cnt_en),
        .vec_o  (vec),
        .last_o (vec_last)
    );

    // Sweep controller: launch, per-vector scoring, first-failure capture, finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= '0;
            cex_valid_q  <= 1'b0;
            cex_in_q     <= '0;
            cex_out_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        fail_count_q <= '0;
                        cex_valid_q  <= 1'b0;
                        cex_in_q     <= '0;
                        cex_out_q    <= '0;
                    end
                end
                RUN: begin
`ifdef SKF_STOP_ON_FAIL_EN
                    if (vec_fail) begin
                        fail_count_q <= (NUM_IN + 1)'(1);
                        cex_valid_q  <= 1'b1;
                        cex_in_q     <= vec;
                        cex_out_q    <= skf_out;
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        pass_q       <= 1'b0;
                    end else if (vec_last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_count_q == '0);
                    end
`else
                    if (vec_fail) begin
                        fail_count_q <= fail_count_inc;
                        if (!cex_valid_q) begin
                            cex_valid_q <= 1'b1;
                            cex_in_q    <= vec;
                            cex_out_q   <= skf_out;
                        end
                    end
                    // A failure on the terminal vector is folded into pass here.
                    if (vec_last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !vec_fail && (fail_count_q == '0);
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign skf_in     = vec;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fail_count_q;
    assign cex_valid  = cex_valid_q;
    assign cex_in     = cex_in_q;
    assign cex_out    = cex_out_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_skolem_exhaustive_checker.sv
// tb_skolem_exhaustive_checker: directed bench for the 5-input / 2-output checker.
// A behavioural Skolem stub with selectable personalities feeds skf_out.
module tb_skolem_exhaustive_checker;

    localparam int NUM_IN  = 5;
    localparam int NUM_OUT = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [NUM_IN-1:0]  skf_in;
    logic [NUM_OUT-1:0] skf_out;
    logic               busy;
    logic               done;
    logic               pass;
    logic [NUM_IN:0]    fail_count;
    logic               cex_valid;
    logic [NUM_IN-1:0]  cex_in;
    logic [NUM_OUT-1:0] cex_out;
    logic [1:0]         dbg_state;

    int checks   = 0;
    int failures = 0;
    int stub_mode = 0;
    int cyc;

    // Clock
    always #5 clk = ~clk;

    // Skolem stub personalities:
    // 0 golden {0, ^in}; 1 stuck 00; 2 alternative valid netlist;
    // 3 golden except vector 31, whose out[0] is flipped.
    always_comb begin
        case (stub_mode)
            0:       skf_out = {1'b0, ^skf_in};
            1:       skf_out = 2'b00;
            2:       skf_out = {skf_in[2] ^ skf_in[3] ^ skf_in[4], skf_in[0] ^ skf_in[1]};
            default: skf_out = {1'b0, (^skf_in) ^ (skf_in == 5'd31)};
        endcase
    end

    skolem_exhaustive_checker #(
        .NUM_IN  (NUM_IN),
        .NUM_OUT (NUM_OUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .skf_in     (skf_in),
        .skf_out    (skf_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_count (fail_count),
        .cex_valid  (cex_valid),
        .cex_in     (cex_in),
        .cex_out    (cex_out),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Driver: single-cycle start pulse, called and returning on a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy cycles until done, optionally re-pulsing start at busy cycle
    // number inject_at. Bounded so a stuck DUT still reaches the summary.
    task automatic run_sweep(input int inject_at, output int n);
        n = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (busy) n++;
            start = (inject_at > 0) && (n == inject_at);
            @(negedge clk);
        end
        start = 1'b0;
        check("sweep_reaches_done", 32'(done), 32'd1);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_state",      32'(dbg_state),  32'd0);
        check("rst_skf_in",     32'(skf_in),     32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_pass",       32'(pass),       32'd0);
        check("rst_fail_count", 32'(fail_count), 32'd0);
        check("rst_cex_valid",  32'(cex_valid),  32'd0);
        check("rst_cex_in",     32'(cex_in),     32'd0);
        check("rst_cex_out",    32'(cex_out),    32'd0);
        @(negedge clk);

        // Golden stub: full clean sweep
        stub_mode = 0;
        pulse_start();
        run_sweep(0, cyc);
        check("gold_cycles",     32'(cyc),        32'd32);
        check("gold_busy",       32'(busy),       32'd0);
        check("gold_pass",       32'(pass),       32'd1);
        check("gold_fail_count", 32'(fail_count), 32'd0);
        check("gold_cex_valid",  32'(cex_valid),  32'd0);
        check("gold_skf_in_hold", 32'(skf_in),    32'd31);
        repeat (3) @(negedge clk);
        check("gold_done_hold",  32'(done),       32'd1);
        check("gold_state_done", 32'(dbg_state),  32'd2);

        // Stuck stub, launched from DONE
        stub_mode = 1;
        pulse_start();
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_pass", 32'(pass), 32'd0);
        run_sweep(0, cyc);
`ifdef SKF_STOP_ON_FAIL_EN
        check("stuck_cycles",     32'(cyc),        32'd2);
        check("stuck_fail_count", 32'(fail_count), 32'd1);
        check("stuck_skf_in",     32'(skf_in),     32'd1);
`else
        check("stuck_cycles",     32'(cyc),        32'd32);
        check("stuck_fail_count", 32'(fail_count), 32'd16);
        check("stuck_skf_in",     32'(skf_in),     32'd31);
`endif
        check("stuck_pass",      32'(pass),      32'd0);
        check("stuck_cex_valid", 32'(cex_valid), 32'd1);
        check("stuck_cex_in",    32'(cex_in),    32'd1);
        check("stuck_cex_out",   32'(cex_out),   32'd0);

        // Alternative valid netlist, start re-pulsed mid-sweep
        stub_mode = 2;
        pulse_start();
        check("clear_cex_valid",  32'(cex_valid),  32'd0);
        check("clear_fail_count", 32'(fail_count), 32'd0);
        check("clear_cex_in",     32'(cex_in),     32'd0);
        run_sweep(5, cyc);
        check("net_cycles",     32'(cyc),        32'd32);
        check("net_pass",       32'(pass),       32'd1);
        check("net_fail_count", 32'(fail_count), 32'd0);

        // Failure only on the terminal vector
        stub_mode = 3;
        pulse_start();
        run_sweep(0, cyc);
        check("last_cycles",     32'(cyc),        32'd32);
        check("last_fail_count", 32'(fail_count), 32'd1);
        check("last_pass",       32'(pass),       32'd0);
        check("last_cex_valid",  32'(cex_valid),  32'd1);
        check("last_cex_in",     32'(cex_in),     32'd31);
        check("last_cex_out",    32'(cex_out),    32'd0);

        // Reset at busy cycle 10 of a failing sweep
        stub_mode = 1;
        pulse_start();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",       32'(busy),       32'd0);
        check("midrst_done",       32'(done),       32'd0);
        check("midrst_fail_count", 32'(fail_count), 32'd0);
        check("midrst_cex_valid",  32'(cex_valid),  32'd0);
        check("midrst_skf_in",     32'(skf_in),     32'd0);
        check("midrst_state",      32'(dbg_state),  32'd0);
        pulse_start();
        run_sweep(0, cyc);
`ifdef SKF_STOP_ON_FAIL_EN
        check("after_rst_cycles",     32'(cyc),        32'd2);
        check("after_rst_fail_count", 32'(fail_count), 32'd1);
`else
        check("after_rst_cycles",     32'(cyc),        32'd32);
        check("after_rst_fail_count", 32'(fail_count), 32'd16);
`endif

        // rst and start on the same edge: reset wins
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("prio_state", 32'(dbg_state), 32'd0);
        check("prio_busy",  32'(busy),      32'd0);
        check("prio_done",  32'(done),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
